pool_window_buffer: RTL and testbench

Parametrised ping-pong row-pair buffer between a convolution layer and its 2x2 max-pooling stage. It accepts one pixel per beat for all channels in parallel, stores two image rows per bank, and emits non-overlapping 2x2 windows per channel. Both sides use valid/ready backpressure. Image width, height, channel count and data width are generics, so the block serves C1, C3 and any later conv layer.

---
 rtl/pool_window_buffer.sv | 169 ++++++++++++++++
 tb/tb_pool_window_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_buffer.sv
// Ping-pong row-pair buffer feeding a 2x2 max-pooling stage: writes pixels row-major
// into two banks of two rows and emits non-overlapping 2x2 windows. Define POOL_MAX_EN to emit the window max instead.
module pool_window_buffer #(
  parameter int DATA_W = 8,
  parameter int CH     = 6,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*DATA_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef POOL_MAX_EN
  output logic [CH*DATA_W-1:0]   out_data,
`else
  output logic [CH*4*DATA_W-1:0] out_data,
`endif
  output logic                   out_row_last,
  output logic                   out_last
);

  localparam int CW    = $clog2(IMG_W);
  localparam int PW    = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;
  localparam int AW    = CW + 2;
  localparam int PIX_W = CH * DATA_W;
`ifdef POOL_MAX_EN
  localparam int OUT_W = CH * DATA_W;
`else
  localparam int OUT_W = CH * 4 * DATA_W;
`endif

  localparam logic [CW-1:0] WR_COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] RD_COL_LAST = CW'(IMG_W - 2);
  localparam logic [PW-1:0] PAIR_LAST   = PW'(IMG_H / 2 - 1);

  typedef enum logic {R_WAIT, R_DRAIN} rd_state_t;

  // Address = {bank, row, col}; columns beyond IMG_W-1 are never touched.
  logic [PIX_W-1:0] mem [0:(2**AW)-1];

  logic [CW-1:0] wr_col_reg;
  logic          wr_row_reg;
  logic          wr_bank_reg;
  logic [1:0]    full_reg;
  logic [1:0]    full_next;

  rd_state_t     rd_state_reg;
  logic [CW-1:0] rd_col_reg;
  logic [CW-1:0] rd_col_odd;
  logic          rd_bank_reg;
  logic [PW-1:0] rd_pair_reg;

  logic wr_fire;
  logic wr_pair_done;
  logic rd_load;
  logic rd_pair_done;

  logic [PIX_W-1:0] pix_tl, pix_tr, pix_bl, pix_br;
  logic [OUT_W-1:0] win_next;

  assign in_ready     = ~full_reg[wr_bank_reg];
  assign wr_fire      = in_valid & in_ready;
  assign wr_pair_done = wr_fire & wr_row_reg & (wr_col_reg == WR_COL_LAST);

  assign rd_load      = (rd_state_reg == R_DRAIN) & (~out_valid | out_ready);
  assign rd_pair_done = rd_load & (rd_col_reg == RD_COL_LAST);

  // The writer only ever targets a non-full bank and the reader only clears a full one,
  // so a same-edge set and clear always hit different banks.
  always_comb begin
    full_next = full_reg;
    if (wr_pair_done) full_next[wr_bank_reg] = 1'b1;
    if (rd_pair_done) full_next[rd_bank_reg] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank_reg, wr_row_reg, wr_col_reg}] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_col_reg  <= '0;
      wr_row_reg  <= 1'b0;
      wr_bank_reg <= 1'b0;
    end else if (wr_fire) begin
      if (wr_col_reg == WR_COL_LAST) begin
        wr_col_reg <= '0;
        wr_row_reg <= ~wr_row_reg;
        if (wr_row_reg) wr_bank_reg <= ~wr_bank_reg;
      end else begin
        wr_col_reg <= wr_col_reg + CW'(1);
      end
    end
  end

  // rd_col is always even, so the right-hand column is just rd_col with bit 0 set.
  assign rd_col_odd = rd_col_reg | CW'(1);
  assign pix_tl     = mem[{rd_bank_reg, 1'b0, rd_col_reg}];
  assign pix_tr     = mem[{rd_bank_reg, 1'b0, rd_col_odd}];
  assign pix_bl     = mem[{rd_bank_reg, 1'b1, rd_col_reg}];
  assign pix_br     = mem[{rd_bank_reg, 1'b1, rd_col_odd}];

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [DATA_W-1:0] tl, tr, bl, br;
      assign tl = pix_tl[gi*DATA_W +: DATA_W];
      assign tr = pix_tr[gi*DATA_W +: DATA_W];
      assign bl = pix_bl[gi*DATA_W +: DATA_W];
      assign br = pix_br[gi*DATA_W +: DATA_W];
`ifdef POOL_MAX_EN
      logic [DATA_W-1:0] top_max, bot_max;
      assign top_max = (tl > tr) ? tl : tr;
      assign bot_max = (bl > br) ? bl : br;
      assign win_next[gi*DATA_W +: DATA_W] = (top_max > bot_max) ? top_max : bot_max;
`else
      assign win_next[gi*4*DATA_W +: 4*DATA_W] = {tl, tr, bl, br};
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      full_reg     <= 2'b00;
      rd_state_reg <= R_WAIT;
      rd_col_reg   <= '0;
      rd_bank_reg  <= 1'b0;
      rd_pair_reg  <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row_last <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      full_reg <= full_next;

      case (rd_state_reg)
        R_WAIT: begin
          if (full_reg[rd_bank_reg]) rd_state_reg <= R_DRAIN;
        end
        R_DRAIN: begin
          if (rd_load) begin
            if (rd_col_reg == RD_COL_LAST) begin
              rd_col_reg  <= '0;
              rd_bank_reg <= ~rd_bank_reg;
              rd_pair_reg <= (rd_pair_reg == PAIR_LAST) ? '0 : rd_pair_reg + PW'(1);
              // Skip the idle cycle when the other bank filled up while we were draining.
              if (!full_reg[~rd_bank_reg]) rd_state_reg <= R_WAIT;
            end else begin
              rd_col_reg <= rd_col_reg + CW'(2);
            end
          end
        end
        default: rd_state_reg <= R_WAIT;
      endcase

      if (rd_load) begin
        out_valid    <= 1'b1;
        out_data     <= win_next;
        out_row_last <= (rd_col_reg == RD_COL_LAST);
        out_last     <= (rd_col_reg == RD_COL_LAST) && (rd_pair_reg == PAIR_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: a 4x4x2 instance with hand-computed windows and a
// default 28x28x6 instance checked against a window model under varied backpressure.
module tb_pool_window_buffer;

  localparam int DW   = 8;
  localparam int B_CH = 6;
  localparam int B_W  = 28;
  localparam int B_H  = 28;
  localparam int S_CH = 2;
  localparam int S_W  = 4;
  localparam int S_H  = 4;
  localparam int B_BEATS = B_W * B_H;
  localparam int B_WINS  = (B_W / 2) * (B_H / 2);
  localparam int B_WPR   = B_W / 2;
`ifdef POOL_MAX_EN
  localparam int B_OW = B_CH * DW;
  localparam int S_OW = S_CH * DW;
`else
  localparam int B_OW = B_CH * 4 * DW;
  localparam int S_OW = S_CH * 4 * DW;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_row_last, b_out_last;
  logic [B_CH*DW-1:0]   b_in_data;
  logic [B_OW-1:0]      b_out_data;
  logic                 s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_row_last, s_out_last;
  logic [S_CH*DW-1:0]   s_in_data;
  logic [S_OW-1:0]      s_out_data;

  pool_window_buffer dut (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_row_last(b_out_row_last), .out_last(b_out_last)
  );

  pool_window_buffer #(.DATA_W(DW), .CH(S_CH), .IMG_W(S_W), .IMG_H(S_H)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_row_last(s_out_row_last), .out_last(s_out_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state for the large instance.
  int in_frame, in_beat, in_accepted;
  int out_frame, out_k, out_total, last_count;
  int cyc, e_cyc, first_ov, stall_cycles;

  function automatic logic [7:0] bpix(int f, int r, int c, int ch);
    return 8'((r * B_W + c) * 3 + ch * 41 + f * 17);
  endfunction

  function automatic logic [B_CH*DW-1:0] bbeat(int f, int n);
    logic [B_CH*DW-1:0] v;
    for (int ch = 0; ch < B_CH; ch++) v[ch*DW +: DW] = bpix(f, n / B_W, n % B_W, ch);
    return v;
  endfunction

  function automatic logic [7:0] max4(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [B_OW-1:0] bwin(int f, int k);
    logic [B_OW-1:0] v;
    logic [7:0] tl, tr, bl, br;
    int r, c;
    r = (k / B_WPR) * 2;
    c = (k % B_WPR) * 2;
    v = '0;
    for (int ch = 0; ch < B_CH; ch++) begin
      tl = bpix(f, r, c, ch);
      tr = bpix(f, r, c + 1, ch);
      bl = bpix(f, r + 1, c, ch);
      br = bpix(f, r + 1, c + 1, ch);
`ifdef POOL_MAX_EN
      v[ch*DW +: DW] = max4(tl, tr, bl, br);
`else
      v[ch*4*DW +: 4*DW] = {tl, tr, bl, br};
`endif
    end
    return v;
  endfunction

  task automatic b_clear_model(input int f0);
    in_frame = f0; in_beat = 0; in_accepted = 0;
    out_frame = f0; out_k = 0; out_total = 0; last_count = 0;
    cyc = 0; e_cyc = -1; first_ov = -1; stall_cycles = 0;
  endtask

  // One clock of the large instance: drive, score any window handed over, advance on the edge.
  task automatic b_cycle(input bit drv, input bit rdy, input int n_frames);
    bit fire;
    logic [B_OW-1:0] exp_d;
    bit exp_rl, exp_l;
    b_in_valid  = drv && (in_frame < n_frames);
    b_in_data   = bbeat(in_frame, in_beat);
    b_out_ready = rdy;
    fire = b_in_valid && b_in_ready;
    if (b_in_valid && !b_in_ready) stall_cycles++;
    if (b_out_valid && first_ov < 0) first_ov = cyc;
    if (b_out_valid && b_out_ready) begin
      exp_d  = bwin(out_frame, out_k);
      exp_rl = (out_k % B_WPR) == B_WPR - 1;
      exp_l  = (out_k == B_WINS - 1);
      n_checks++;
      if (b_out_data !== exp_d || b_out_row_last !== exp_rl || b_out_last !== exp_l) begin
        n_fail++;
        $display("FAIL window f%0d k%0d: got data=%h rl=%b last=%b, expected data=%h rl=%b last=%b",
                 out_frame, out_k, b_out_data, b_out_row_last, b_out_last, exp_d, exp_rl, exp_l);
      end
      if (b_out_last) last_count++;
      out_total++;
      out_k++;
      if (out_k == B_WINS) begin out_k = 0; out_frame++; end
    end
    @(posedge clk); #1;
    cyc++;
    if (fire) begin
      if (in_frame == out_frame && in_beat == 2 * B_W - 1 && e_cyc < 0) e_cyc = cyc;
      in_accepted++;
      in_beat++;
      if (in_beat == B_BEATS) begin in_beat = 0; in_frame++; end
    end
  endtask

  task automatic idle_inputs();
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== '0 || b_out_last !== 1'b0 || b_out_row_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: got in_ready=%b out_valid=%b last=%b rl=%b, expected 1 0 0 0 with zero data",
               b_in_ready, b_out_valid, b_out_last, b_out_row_last);
    end
    n_checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got in_ready=%b out_valid=%b data=%h, expected 1 0 0", s_in_ready, s_out_valid, s_out_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: got in_ready=%b out_valid=%b, expected 1 0", b_in_ready, b_out_valid);
    end
  endtask

  // Streams one 4x4 frame into the small instance and returns the first windows seen.
  task automatic s_stream(input logic [S_CH*DW-1:0] beats [16], output logic [S_OW-1:0] got_d [4],
                          output bit got_rl [4], output bit got_l [4], output int got);
    int beat;
    bit fire;
    beat = 0; got = 0;
    for (int i = 0; i < 4; i++) begin got_d[i] = '0; got_rl[i] = 1'b0; got_l[i] = 1'b0; end
    s_out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      s_in_valid = (beat < 16);
      s_in_data  = beats[beat % 16];
      fire = s_in_valid && s_in_ready;
      if (s_out_valid && s_out_ready) begin
        if (got < 4) begin got_d[got] = s_out_data; got_rl[got] = s_out_row_last; got_l[got] = s_out_last; end
        got++;
      end
      @(posedge clk); #1;
      if (fire) beat++;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic test_small_frame();
    logic [S_CH*DW-1:0] beats [16];
    logic [S_OW-1:0] got_d [4];
    logic [S_OW-1:0] exp_d [4];
    bit got_rl [4];
    bit got_l [4];
    bit exp_rl [4];
    bit exp_l [4];
    int got;
    apply_reset();
    for (int n = 0; n < 16; n++) beats[n] = {8'hF0 + 8'(n), 8'(n)};
`ifdef POOL_MAX_EN
    exp_d[0] = 16'hF505; exp_d[1] = 16'hF707; exp_d[2] = 16'hFD0D; exp_d[3] = 16'hFF0F;
`else
    exp_d[0] = 64'hF0F1F4F5_00010405;
    exp_d[1] = 64'hF2F3F6F7_02030607;
    exp_d[2] = 64'hF8F9FCFD_08090C0D;
    exp_d[3] = 64'hFAFBFEFF_0A0B0E0F;
`endif
    exp_rl[0] = 0; exp_rl[1] = 1; exp_rl[2] = 0; exp_rl[3] = 1;
    exp_l[0]  = 0; exp_l[1]  = 0; exp_l[2]  = 0; exp_l[3]  = 1;
    s_stream(beats, got_d, got_rl, got_l, got);
    n_checks++;
    if (got !== 4) begin
      n_fail++;
      $display("FAIL small_count: got %0d windows, expected 4", got);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[i] !== exp_d[i] || got_rl[i] !== exp_rl[i] || got_l[i] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL small_win%0d: got data=%h rl=%b last=%b, expected data=%h rl=%b last=%b",
                 i, got_d[i], got_rl[i], got_l[i], exp_d[i], exp_rl[i], exp_l[i]);
      end
    end
  endtask

`ifdef POOL_MAX_EN
  task automatic test_pool_max();
    logic [S_CH*DW-1:0] beats [16];
    logic [S_OW-1:0] got_d [4];
    bit got_rl [4];
    bit got_l [4];
    int got;
    apply_reset();
    for (int n = 0; n < 16; n++) beats[n] = '0;
    beats[0] = {8'h80, 8'h03};
    beats[1] = {8'h01, 8'hFF};
    beats[4] = {8'h02, 8'h10};
    beats[5] = {8'h81, 8'h7F};
    s_stream(beats, got_d, got_rl, got_l, got);
    n_checks++;
    if (got_d[0] !== 16'h81FF) begin
      n_fail++;
      $display("FAIL pool_max: got %h, expected 81ff", got_d[0]);
    end
  endtask
`endif

  task automatic test_stream();
    int c;
    apply_reset();
    b_clear_model(0);
    c = 0;
    while (out_total < B_WINS && c < 2000) begin b_cycle(1, 1, 1); c++; end
    repeat (20) b_cycle(1, 1, 1);
    n_checks++;
    if (stall_cycles !== 0) begin n_fail++; $display("FAIL stream_stall: got %0d stalled cycles, expected 0", stall_cycles); end
    n_checks++;
    if (out_total !== B_WINS) begin n_fail++; $display("FAIL stream_count: got %0d windows, expected %0d", out_total, B_WINS); end
    n_checks++;
    if (last_count !== 1) begin n_fail++; $display("FAIL stream_last: got %0d out_last, expected 1", last_count); end
    n_checks++;
    if (e_cyc < 0 || first_ov - e_cyc !== 2) begin
      n_fail++;
      $display("FAIL stream_latency: got %0d cycles from beat 56 to out_valid, expected 2", first_ov - e_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [B_OW-1:0] held;
    int c;
    apply_reset();
    b_clear_model(0);
    c = 0;
    while (!b_out_valid && c < 200) begin b_cycle(1, 0, 1); c++; end
    held = b_out_data;
    repeat (150) b_cycle(1, 0, 1);
    n_checks++;
    if (in_accepted !== 2 * 2 * B_W || b_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_fill: got %0d beats in_ready=%b, expected %0d beats in_ready=0", in_accepted, b_in_ready, 4 * B_W);
    end
    n_checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== held || b_out_data !== bwin(0, 0)) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%b data=%h, expected valid=1 data=%h", b_out_valid, b_out_data, bwin(0, 0));
    end
    c = 0;
    while (out_total < B_WINS && c < 3000) begin b_cycle(1, 1, 1); c++; end
    repeat (20) b_cycle(1, 1, 1);
    n_checks++;
    if (out_total !== B_WINS || last_count !== 1) begin
      n_fail++;
      $display("FAIL bp_resume: got %0d windows %0d last, expected %0d and 1", out_total, last_count, B_WINS);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    apply_reset();
    b_clear_model(0);
    c = 0;
    while (out_total < 3 * B_WINS && c < 8000) begin b_cycle(1, 1'($urandom_range(0, 1)), 3); c++; end
    repeat (30) b_cycle(1, 1, 3);
    n_checks++;
    if (out_total !== 3 * B_WINS || last_count !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d windows %0d last, expected %0d and 3", out_total, last_count, 3 * B_WINS);
    end
    n_checks++;
    if (in_accepted !== 3 * B_BEATS) begin
      n_fail++;
      $display("FAIL b2b_beats: got %0d beats, expected %0d", in_accepted, 3 * B_BEATS);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    apply_reset();
    b_clear_model(7);
    c = 0;
    while (in_accepted < 30 && c < 100) begin b_cycle(1, 1, 8); c++; end
    b_in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_flags: got out_valid=%b in_ready=%b, expected 0 1", b_out_valid, b_in_ready);
    end
    b_clear_model(2);
    c = 0;
    while (out_total < B_WINS && c < 2000) begin b_cycle(1, 1, 3); c++; end
    repeat (20) b_cycle(1, 1, 3);
    n_checks++;
    if (out_total !== B_WINS || last_count !== 1) begin
      n_fail++;
      $display("FAIL midreset_frame: got %0d windows %0d last, expected %0d and 1", out_total, last_count, B_WINS);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_small_frame();
`ifdef POOL_MAX_EN
    test_pool_max();
`endif
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
